// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores to data memory over req/ack, registers results into MW_*,
// stalls upstream during an access, and turns misaligned or timed-out accesses into bubbles.
//
// state  | meaning
// IDLE   | evaluate the XM_* instruction; pass through, flag misalign, or issue a request
// ACCESS | request outstanding; wait for dm_ack or abort when the timeout counter expires
module memory_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  XM_RD,
    input  logic [31:0] XM_B,
    input  logic [31:0] ALUout,
    input  logic        XM_MemWrite,
    input  logic        XM_MemToReg,
    input  logic        XM_RegWrite,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_ALUout,
    output logic [31:0] MW_MemData,
    output logic        MW_MemToReg,
    output logic        MW_RegWrite,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        w_memop;
    logic        w_aligned;
    logic        w_timeout;
    logic        w_stall;

    logic        w_req_nxt;
    logic        w_we_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic [4:0]  w_rd_nxt;
    logic [31:0] w_aluout_nxt;
    logic [31:0] w_memdata_nxt;
    logic        w_memtoreg_nxt;
    logic        w_regwrite_nxt;
    logic        w_misalign_nxt;
    logic        w_bus_err_nxt;

    assign w_memop   = XM_MemWrite | XM_MemToReg;
    assign w_aligned = (ALUout[1:0] == 2'b00);
    assign w_timeout = (r_state == S_ACCESS) && (r_cnt == CNT_LAST);

    // Gated by reset so the stall drops together with dm_req while reset is held.
    assign mem_stall = rst & w_stall;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stall        = 1'b0;
        w_req_nxt      = dm_req;
        w_we_nxt       = dm_we;
        w_addr_nxt     = dm_addr;
        w_wdata_nxt    = dm_wdata;
        w_rd_nxt       = MW_RD;
        w_aluout_nxt   = MW_ALUout;
        w_memdata_nxt  = MW_MemData;
        w_memtoreg_nxt = MW_MemToReg;
        w_regwrite_nxt = MW_RegWrite;
        w_misalign_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_memop) begin
                    w_rd_nxt       = XM_RD;
                    w_aluout_nxt   = ALUout;
                    w_memtoreg_nxt = XM_MemToReg;
                    w_regwrite_nxt = XM_RegWrite;
                end else if (!w_aligned) begin
                    w_rd_nxt       = XM_RD;
                    w_aluout_nxt   = ALUout;
                    w_memtoreg_nxt = 1'b0;
                    w_regwrite_nxt = 1'b0;
                    w_misalign_nxt = 1'b1;
                end else begin
                    w_stall        = 1'b1;
                    w_state_nxt    = S_ACCESS;
                    w_cnt_nxt      = 8'd0;
                    w_req_nxt      = 1'b1;
                    w_we_nxt       = XM_MemWrite;
                    w_addr_nxt     = ALUout;
                    w_wdata_nxt    = XM_B;
                    w_memtoreg_nxt = 1'b0;
                    w_regwrite_nxt = 1'b0;
                end
            end
            S_ACCESS: begin
                w_stall   = !dm_ack && !w_timeout;
                w_cnt_nxt = r_cnt + 8'd1;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (dm_ack) begin
                    w_state_nxt    = S_IDLE;
                    w_req_nxt      = 1'b0;
                    if (!dm_we) begin
                        w_memdata_nxt = dm_rdata;
                    end
                    w_rd_nxt       = XM_RD;
                    w_aluout_nxt   = ALUout;
                    w_memtoreg_nxt = XM_MemToReg;
                    w_regwrite_nxt = XM_RegWrite;
                end else if (w_timeout) begin
                    w_state_nxt    = S_IDLE;
                    w_req_nxt      = 1'b0;
                    w_bus_err_nxt  = 1'b1;
                    w_memtoreg_nxt = 1'b0;
                    w_regwrite_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_wdata    <= 32'd0;
            MW_RD       <= 5'd0;
            MW_ALUout   <= 32'd0;
            MW_MemData  <= 32'd0;
            MW_MemToReg <= 1'b0;
            MW_RegWrite <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            dm_req      <= w_req_nxt;
            dm_we       <= w_we_nxt;
            dm_addr     <= w_addr_nxt;
            dm_wdata    <= w_wdata_nxt;
            MW_RD       <= w_rd_nxt;
            MW_ALUout   <= w_aluout_nxt;
            MW_MemData  <= w_memdata_nxt;
            MW_MemToReg <= w_memtoreg_nxt;
            MW_RegWrite <= w_regwrite_nxt;
            misalign    <= w_misalign_nxt;
            bus_err     <= w_bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT=4): pass-through, load, store,
// misalign, timeout with ack tie-break, reset mid-access and back-to-back loads.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  XM_RD;
    logic [31:0] XM_B;
    logic [31:0] ALUout;
    logic        XM_MemWrite;
    logic        XM_MemToReg;
    logic        XM_RegWrite;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_stall;
    logic [4:0]  MW_RD;
    logic [31:0] MW_ALUout;
    logic [31:0] MW_MemData;
    logic        MW_MemToReg;
    logic        MW_RegWrite;
    logic        misalign;
    logic        bus_err;

    int n_pass = 0;
    int n_total = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .XM_RD(XM_RD), .XM_B(XM_B), .ALUout(ALUout),
        .XM_MemWrite(XM_MemWrite), .XM_MemToReg(XM_MemToReg), .XM_RegWrite(XM_RegWrite),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .mem_stall(mem_stall),
        .MW_RD(MW_RD), .MW_ALUout(MW_ALUout), .MW_MemData(MW_MemData),
        .MW_MemToReg(MW_MemToReg), .MW_RegWrite(MW_RegWrite),
        .misalign(misalign), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] b, input logic [31:0] alu,
                         input logic mw, input logic mtr, input logic rw);
        XM_RD       = rd;
        XM_B        = b;
        ALUout      = alu;
        XM_MemWrite = mw;
        XM_MemToReg = mtr;
        XM_RegWrite = rw;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("rst_req", dm_req, 0);
        chk("rst_mwrd", MW_RD, 0);
        chk("rst_regwr", MW_RegWrite, 0);
        chk("rst_stall", mem_stall, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // 1: non-memop pass-through
        drive(5'd5, 32'd0, 32'h10, 1'b0, 1'b0, 1'b1);
        chk("t1_stall", mem_stall, 0);
        tick();
        chk("t1_alu", MW_ALUout, 32'h10);
        chk("t1_rd", MW_RD, 5);
        chk("t1_regwr", MW_RegWrite, 1);
        chk("t1_req", dm_req, 0);

        // 2: load, ack on 4th ACCESS cycle (also the TIMEOUT-1 cycle: ack must win)
        drive(5'd8, 32'd0, 32'h40, 1'b0, 1'b1, 1'b1);
        chk("t2_stall_issue", mem_stall, 1);
        tick();
        chk("t2_req", dm_req, 1);
        chk("t2_we", dm_we, 0);
        chk("t2_addr", dm_addr, 32'h40);
        chk("t2_bubble", MW_RegWrite, 0);
        chk("t2_stall_a0", mem_stall, 1);
        tick();
        chk("t2_stall_a1", mem_stall, 1);
        tick();
        chk("t2_stall_a2", mem_stall, 1);
        chk("t2_req_held", dm_req, 1);
        tick();
        dm_ack = 1'b1;
        dm_rdata = 32'hDEADBEEF;
        #1;
        chk("t2_stall_ack", mem_stall, 0);
        tick();
        dm_ack = 1'b0;
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t2_data", MW_MemData, 32'hDEADBEEF);
        chk("t2_rd", MW_RD, 8);
        chk("t2_mtr", MW_MemToReg, 1);
        chk("t2_regwr", MW_RegWrite, 1);
        chk("t2_req_off", dm_req, 0);
        chk("t2_no_buserr", bus_err, 0);

        // 3: store, ack on first ACCESS cycle; MW_MemData must hold
        drive(5'd0, 32'h12345678, 32'h80, 1'b1, 1'b0, 1'b0);
        chk("t3_stall_issue", mem_stall, 1);
        tick();
        chk("t3_we", dm_we, 1);
        chk("t3_wdata", dm_wdata, 32'h12345678);
        chk("t3_addr", dm_addr, 32'h80);
        chk("t3_req", dm_req, 1);
        dm_ack = 1'b1;
        dm_rdata = 32'hAAAA5555;
        #1;
        chk("t3_stall_ack", mem_stall, 0);
        tick();
        dm_ack = 1'b0;
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t3_regwr", MW_RegWrite, 0);
        chk("t3_req_off", dm_req, 0);
        chk("t3_data_held", MW_MemData, 32'hDEADBEEF);

        // 4: misaligned load
        drive(5'd9, 32'd0, 32'h42, 1'b0, 1'b1, 1'b1);
        chk("t4_stall", mem_stall, 0);
        tick();
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_misalign", misalign, 1);
        chk("t4_req", dm_req, 0);
        chk("t4_regwr", MW_RegWrite, 0);
        chk("t4_mtr", MW_MemToReg, 0);
        chk("t4_alu", MW_ALUout, 32'h42);
        tick();
        chk("t4_misalign_pulse", misalign, 0);

        // 5: read with no ack times out after 4 ACCESS cycles
        drive(5'd3, 32'd0, 32'h100, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t5_req_a0", dm_req, 1);
        tick();
        tick();
        chk("t5_req_a2", dm_req, 1);
        chk("t5_stall_a2", mem_stall, 1);
        tick();
        chk("t5_req_a3", dm_req, 1);
        chk("t5_stall_to", mem_stall, 0);
        tick();
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_req_off", dm_req, 0);
        chk("t5_buserr", bus_err, 1);
        chk("t5_regwr", MW_RegWrite, 0);
        chk("t5_mtr", MW_MemToReg, 0);
        dm_ack = 1'b1;
        dm_rdata = 32'h55555555;
        tick();
        dm_ack = 1'b0;
        chk("t5_buserr_pulse", bus_err, 0);
        chk("t5_idle_ack_req", dm_req, 0);
        chk("t5_idle_ack_data", MW_MemData, 32'hDEADBEEF);

        // 6a: reset mid-access, then a normal pass-through
        drive(5'd4, 32'd0, 32'h200, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t6_req_pre", dm_req, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_req", dm_req, 0);
        chk("t6_rst_stall", mem_stall, 0);
        chk("t6_rst_rd", MW_RD, 0);
        chk("t6_rst_alu", MW_ALUout, 0);
        chk("t6_rst_data", MW_MemData, 0);
        rst = 1'b1;
        drive(5'd6, 32'd0, 32'h20, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t6_pass_rd", MW_RD, 6);
        chk("t6_pass_alu", MW_ALUout, 32'h20);
        chk("t6_pass_regwr", MW_RegWrite, 1);

        // 6b: back-to-back loads to 0x0 and 0x4
        drive(5'd1, 32'd0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t6_b0_req", dm_req, 1);
        chk("t6_b0_addr", dm_addr, 32'h0);
        dm_ack = 1'b1;
        dm_rdata = 32'h11111111;
        tick();
        dm_ack = 1'b0;
        drive(5'd2, 32'd0, 32'h4, 1'b0, 1'b1, 1'b1);
        chk("t6_b0_data", MW_MemData, 32'h11111111);
        chk("t6_b0_rd", MW_RD, 1);
        chk("t6_b0_req_off", dm_req, 0);
        chk("t6_b1_stall", mem_stall, 1);
        tick();
        chk("t6_b1_req", dm_req, 1);
        chk("t6_b1_addr", dm_addr, 32'h4);
        dm_ack = 1'b1;
        dm_rdata = 32'h22222222;
        tick();
        dm_ack = 1'b0;
        drive(5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_b1_data", MW_MemData, 32'h22222222);
        chk("t6_b1_rd", MW_RD, 2);
        chk("t6_b1_req_off", dm_req, 0);
        tick();
        chk("t6_no_dup", dm_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
